// File: rtl/tv_pkg.sv
// Shared types and helpers for the test-vector checker: FSM states, the
// default-width vector record and the masked output compare.
package tv_pkg;

  localparam int TV_N_IN   = 3;
  localparam int TV_N_OUT  = 1;
  localparam int TV_CMP_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } tv_state_e;

  typedef struct packed {
    logic [TV_N_IN-1:0]  stim;
    logic [TV_N_OUT-1:0] exp_v;
    logic [TV_N_OUT-1:0] mask;
  } tv_vec_t;

  // Bits with mask=0 are don't-care; callers zero-extend to TV_CMP_W.
  function automatic logic tv_mismatch(input logic [TV_CMP_W-1:0] act,
                                       input logic [TV_CMP_W-1:0] exp_v,
                                       input logic [TV_CMP_W-1:0] mask);
    return |((act ^ exp_v) & mask);
  endfunction

endpackage

// File: rtl/tv_vec_mem.sv
// Vector register file: one synchronous write port, asynchronous read.
// Contents are deliberately not reset.
module tv_vec_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 5,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tv_checker.sv
// Self-checking test-vector engine: applies stored stimuli to a combinational
// DUT, waits SETTLE cycles, and compares the masked response to expectation.
module tv_checker
  import tv_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW    = $clog2(DEPTH + 1),
  localparam int W     = N_IN + 2 * N_OUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [NW-1:0]    num_vec,
  input  logic             stop_on_fail,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    first_fail,
  output logic             fail_seen
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SET_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  tv_state_e         state_q, state_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [AW-1:0]     ff_q, ff_d;
  logic              fs_q, fs_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     nv_q, nv_d;
  logic              stop_q, stop_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [W-1:0]      rd_row;
  logic [N_IN-1:0]   rd_stim;
  logic [N_OUT-1:0]  rd_exp;
  logic [N_OUT-1:0]  rd_mask;
  logic              mem_we;
  logic              mis;
  logic [NW-1:0]     nv_sat;

  assign mem_we = wr_en && (state_q == ST_IDLE || state_q == ST_DONE);

  tv_vec_mem #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx_q),
    .rdata (rd_row)
  );

  assign rd_stim = rd_row[W-1 -: N_IN];
  assign rd_exp  = rd_row[2*N_OUT-1 -: N_OUT];
  assign rd_mask = rd_row[N_OUT-1:0];
  assign mis     = tv_mismatch(TV_CMP_W'(dut_out), TV_CMP_W'(rd_exp), TV_CMP_W'(rd_mask));
  assign nv_sat  = (32'(num_vec) > 32'(DEPTH)) ? NW'(DEPTH) : num_vec;

  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    fs_d     = fs_q;
    idx_d    = idx_q;
    nv_d     = nv_q;
    stop_d   = stop_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          nv_d   = nv_sat;
          stop_d = stop_on_fail;
          err_d  = '0;
          fs_d   = 1'b0;
          ff_d   = '0;
          idx_d  = '0;
          pass_d = 1'b0;
          if (nv_sat == '0) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        dut_in_d = rd_stim;
        cnt_d    = '0;
        state_d  = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) state_d = ST_CHECK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK: begin
        if (mis) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fs_q) begin
            fs_d = 1'b1;
            ff_d = idx_q;
          end
        end
        if ((32'(idx_q) + 32'd1 == 32'(nv_q)) || (stop_q && mis)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the busy state computed, including CHECK results.
    if (abort && (state_q == ST_APPLY || state_q == ST_SETTLE || state_q == ST_CHECK)) begin
      state_d = ST_DONE;
      pass_d  = 1'b0;
      err_d   = err_q;
      fs_d    = fs_q;
      ff_d    = ff_q;
      idx_d   = idx_q;
    end

    busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_q     <= '0;
      fs_q     <= 1'b0;
      idx_q    <= '0;
      nv_q     <= '0;
      stop_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      fs_q     <= fs_d;
      idx_q    <= idx_d;
      nv_q     <= nv_d;
      stop_q   <= stop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_seen  = fs_q;

endmodule

// File: tb/tb_tv_checker.sv
// Directed bench for tv_checker: table-driven runs plus hand-written
// sequences for saturation, abort, busy-time hazards and mid-run reset.
module tb_tv_checker;
  import tv_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  tv_vec_t    wr_data = '0;
  logic [3:0] num_vec = '0;
  logic       stop_on_fail = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;

  logic [2:0] dut_in, dut_in_e;
  logic       dut_out, dut_out_e;
  logic       busy, done, pass, fail_seen;
  logic       busy_e, done_e, pass_e, fail_seen_e;
  logic [7:0] err_count;
  logic [1:0] err_count_e;
  logic [2:0] first_fail, first_fail_e;

  // Golden combinational DUT: bit i is the response to stimulus i.
  logic [7:0] golden = 8'hCE;
  assign dut_out   = golden[dut_in];
  assign dut_out_e = golden[dut_in_e];

  always #5 clk = ~clk;

  tv_checker #(.N_IN(3), .N_OUT(1), .DEPTH(8), .SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .stop_on_fail(stop_on_fail), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_seen(fail_seen)
  );

  tv_checker #(.N_IN(3), .N_OUT(1), .DEPTH(8), .SETTLE(1), .ERR_W(2)) dut_e (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .stop_on_fail(stop_on_fail), .start(start), .abort(abort),
    .dut_in(dut_in_e), .dut_out(dut_out_e), .busy(busy_e), .done(done_e), .pass(pass_e),
    .err_count(err_count_e), .first_fail(first_fail_e), .fail_seen(fail_seen_e)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // kind: 0 clean, 1 exp inverted on 2 and 5, 2 same with mask=0 there, 3 all inverted
  task automatic load(input int kind);
    for (int i = 0; i < 8; i++) begin
      tv_vec_t v;
      v.stim  = 3'(i);
      v.exp_v = golden[i];
      v.mask  = 1'b1;
      if ((kind == 1 || kind == 2) && (i == 2 || i == 5)) v.exp_v = ~golden[i];
      if (kind == 2 && (i == 2 || i == 5)) v.mask = 1'b0;
      if (kind == 3) v.exp_v = ~golden[i];
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = v;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen.
  task automatic run(input int nv, input logic sof, output int n);
    num_vec = 4'(nv); stop_on_fail = sof; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  typedef struct {
    string name;
    int    kind;
    int    nv;
    logic  sof;
    int    cyc;
    logic  pass;
    int    err;
    logic  fs;
    int    ff;
    int    din;
  } vec_t;

  vec_t tbl[7];
  int   n;

  initial begin
    tbl[0] = '{"clean",      0, 8, 1'b0, 24, 1'b1, 0, 1'b0, 0, 7};
    tbl[1] = '{"inj_runall", 1, 8, 1'b0, 24, 1'b0, 2, 1'b1, 2, 7};
    tbl[2] = '{"inj_stop",   1, 8, 1'b1,  9, 1'b0, 1, 1'b1, 2, 2};
    tbl[3] = '{"masked",     2, 8, 1'b0, 24, 1'b1, 0, 1'b0, 0, 7};
    tbl[4] = '{"nv0",        2, 0, 1'b0,  0, 1'b1, 0, 1'b0, 0, 7};
    tbl[5] = '{"nv9",        1, 9, 1'b0, 24, 1'b0, 2, 1'b1, 2, 7};
    tbl[6] = '{"nv3",        1, 3, 1'b0,  9, 1'b0, 1, 1'b1, 2, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fs", fail_seen, 0);
    chk("rst_din", dut_in, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      load(tbl[i].kind);
      run(tbl[i].nv, tbl[i].sof, n);
      chk({tbl[i].name, "_cycles"}, n, tbl[i].cyc);
      chk({tbl[i].name, "_done"}, done, 1);
      chk({tbl[i].name, "_busy"}, busy, 0);
      chk({tbl[i].name, "_pass"}, pass, tbl[i].pass);
      chk({tbl[i].name, "_err"}, err_count, tbl[i].err);
      chk({tbl[i].name, "_fs"}, fail_seen, tbl[i].fs);
      chk({tbl[i].name, "_ff"}, first_fail, tbl[i].ff);
      chk({tbl[i].name, "_din"}, dut_in, tbl[i].din);
    end

    // Saturation: all 8 wrong, 8-bit counter reaches 8, 2-bit counter sticks at 3.
    load(3);
    run(8, 1'b0, n);
    chk("sat_cycles", n, 24);
    chk("sat_err8", err_count, 8);
    chk("sat_err2", err_count_e, 3);
    chk("sat_pass2", pass_e, 0);
    chk("sat_ff2", first_fail_e, 0);

    // Abort during SETTLE of idx 3 (dut_in==3 appears on entry to SETTLE).
    load(1);
    num_vec = 4'd8; stop_on_fail = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (dut_in != 3'd3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_idx3", n, 10);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_count, 1);
    chk("abort_ff", first_fail, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_hold_done", done, 1);
    chk("abort_hold_err", err_count, 1);

    // wr_en and start pulsed mid-run must not disturb memory or the run.
    load(0);
    num_vec = 4'd8; stop_on_fail = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = '{stim: 3'd0, exp_v: 1'b1, mask: 1'b1};
    start = 1'b1; num_vec = 4'd1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; num_vec = 4'd8;
    n = 6;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("haz_cycles", n, 24);
    chk("haz_pass", pass, 1);
    chk("haz_err", err_count, 0);
    run(8, 1'b0, n);
    chk("haz_rerun_pass", pass, 1);
    chk("haz_rerun_err", err_count, 0);
    chk("haz_rerun_fs", fail_seen, 0);

    // Asynchronous reset mid-run with errors already counted.
    load(3);
    num_vec = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_rst_err", err_count, 2);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_fs", fail_seen, 0);
    chk("mrst_din", dut_in, 0);
    chk("mrst_ff", first_fail, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
